centroid_div_sched: RTL and testbench

- Time-multiplexes one shared 24-bit sequential divider across the up-to-14 centroid divisions (x_sum/mass and y_sum/mass per cluster) at the end of each k-means iteration.
- Replaces the 14 parallel dividers in the clustering datapath.
- Sits between the accumulation stage (sums and masses) and the divider.
- Returns updated centroids, a done pulse and a convergence flag to the iteration sequencer.

---
 rtl/centroid_div_sched.sv | 189 ++++++++++++++++++
 tb/tb_centroid_div_sched.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/centroid_div_sched.sv
// Shares one sequential divider across all centroid x/y divisions of a k-means pass.
// The inputs are snapshotted on start; slots are walked in ascending order, x before y.
module centroid_div_sched #(
    parameter int NUM_CLUSTERS = 7,
    parameter int X_MAX        = 319,
    parameter int Y_MAX        = 179,
    parameter int TIMEOUT      = 64
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          start_in,
    input  logic [2:0]                    num_balls,
    input  logic [NUM_CLUSTERS-1:0][23:0] x_sum_in,
    input  logic [NUM_CLUSTERS-1:0][23:0] y_sum_in,
    input  logic [NUM_CLUSTERS-1:0][23:0] mass_in,
    input  logic [NUM_CLUSTERS-1:0][8:0]  centroids_x_in,
    input  logic [NUM_CLUSTERS-1:0][7:0]  centroids_y_in,
    output logic [23:0]                   div_dividend_out,
    output logic [23:0]                   div_divisor_out,
    output logic                          div_valid_out,
    input  logic [23:0]                   div_quotient_in,
    input  logic                          div_valid_in,
    output logic [NUM_CLUSTERS-1:0][8:0]  centroids_x_out,
    output logic [NUM_CLUSTERS-1:0][7:0]  centroids_y_out,
    output logic                          busy_out,
    output logic                          done_out,
    output logic                          converged_out,
    output logic                          timeout_err_out
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, SELECT, ISSUE, WAIT, FINISH} state_e;

    state_e                          state_q, state_d;
    logic [2:0]                      slot_q, slot_d;
    logic                            axisY_q, axisY_d;
    logic [TW-1:0]                   timer_q, timer_d;
    logic [2:0]                      numBalls_q, numBalls_d;
    logic [NUM_CLUSTERS-1:0][23:0]   xSum_q, xSum_d;
    logic [NUM_CLUSTERS-1:0][23:0]   ySum_q, ySum_d;
    logic [NUM_CLUSTERS-1:0][23:0]   mass_q, mass_d;
    logic [NUM_CLUSTERS-1:0][8:0]    prevX_q, prevX_d;
    logic [NUM_CLUSTERS-1:0][7:0]    prevY_q, prevY_d;
    logic [NUM_CLUSTERS-1:0][8:0]    centX_q, centX_d;
    logic [NUM_CLUSTERS-1:0][7:0]    centY_q, centY_d;
    logic [23:0]                     dividend_q, dividend_d;
    logic [23:0]                     divisor_q, divisor_d;
    logic                            tracker_q, tracker_d;
    logic                            timeoutErr_q, timeoutErr_d;
    logic [8:0]                      clampX;
    logic [7:0]                      clampY;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= IDLE;
            slot_q       <= '0;
            axisY_q      <= 1'b0;
            timer_q      <= '0;
            numBalls_q   <= '0;
            xSum_q       <= '0;
            ySum_q       <= '0;
            mass_q       <= '0;
            prevX_q      <= '0;
            prevY_q      <= '0;
            centX_q      <= '0;
            centY_q      <= '0;
            dividend_q   <= '0;
            divisor_q    <= '0;
            tracker_q    <= 1'b0;
            timeoutErr_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            axisY_q      <= axisY_d;
            timer_q      <= timer_d;
            numBalls_q   <= numBalls_d;
            xSum_q       <= xSum_d;
            ySum_q       <= ySum_d;
            mass_q       <= mass_d;
            prevX_q      <= prevX_d;
            prevY_q      <= prevY_d;
            centX_q      <= centX_d;
            centY_q      <= centY_d;
            dividend_q   <= dividend_d;
            divisor_q    <= divisor_d;
            tracker_q    <= tracker_d;
            timeoutErr_q <= timeoutErr_d;
        end
    end

    assign clampX = (div_quotient_in > 24'(X_MAX)) ? 9'(X_MAX) : div_quotient_in[8:0];
    assign clampY = (div_quotient_in > 24'(Y_MAX)) ? 8'(Y_MAX) : div_quotient_in[7:0];

    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        axisY_d      = axisY_q;
        timer_d      = timer_q;
        numBalls_d   = numBalls_q;
        xSum_d       = xSum_q;
        ySum_d       = ySum_q;
        mass_d       = mass_q;
        prevX_d      = prevX_q;
        prevY_d      = prevY_q;
        centX_d      = centX_q;
        centY_d      = centY_q;
        dividend_d   = dividend_q;
        divisor_d    = divisor_q;
        tracker_d    = tracker_q;
        timeoutErr_d = timeoutErr_q;

        unique case (state_q)
            IDLE: begin
                if (start_in) begin
                    numBalls_d = num_balls;
                    xSum_d     = x_sum_in;
                    ySum_d     = y_sum_in;
                    mass_d     = mass_in;
                    prevX_d    = centroids_x_in;
                    prevY_d    = centroids_y_in;
                    centX_d    = centroids_x_in;
                    centY_d    = centroids_y_in;
                    slot_d     = '0;
                    axisY_d    = 1'b0;
                    tracker_d  = 1'b1;
                    state_d    = SELECT;
                end
            end
            SELECT: begin
                if (slot_q >= numBalls_q) begin
                    state_d = FINISH;
                end else if (mass_q[slot_q] == 24'd0) begin
                    slot_d = slot_q + 3'd1;
                end else begin
                    dividend_d = axisY_q ? ySum_q[slot_q] : xSum_q[slot_q];
                    divisor_d  = mass_q[slot_q];
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // A missing strobe is treated like a result that left the previous value.
                if (div_valid_in || (timer_q == TW'(TIMEOUT - 1))) begin
                    if (div_valid_in) begin
                        if (axisY_q) begin
                            centY_d[slot_q] = clampY;
                            if (clampY != prevY_q[slot_q]) tracker_d = 1'b0;
                        end else begin
                            centX_d[slot_q] = clampX;
                            if (clampX != prevX_q[slot_q]) tracker_d = 1'b0;
                        end
                    end else begin
                        timeoutErr_d = 1'b1;
                    end
                    if (axisY_q) begin
                        axisY_d = 1'b0;
                        slot_d  = slot_q + 3'd1;
                    end else begin
                        axisY_d = 1'b1;
                    end
                    state_d = SELECT;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign div_dividend_out = dividend_q;
    assign div_divisor_out  = divisor_q;
    assign div_valid_out    = (state_q == ISSUE);
    assign centroids_x_out  = centX_q;
    assign centroids_y_out  = centY_q;
    assign busy_out         = (state_q != IDLE);
    assign done_out         = (state_q == FINISH);
    assign converged_out    = (state_q == FINISH) && tracker_q;
    assign timeout_err_out  = timeoutErr_q;

endmodule

// File: tb/tb_centroid_div_sched.sv
// Scoreboard bench for centroid_div_sched: expected launches and pass results are queued
// by the stimulus and checked by a monitor whenever the DUT launches or signals done.
module tb_centroid_div_sched;

    localparam int NC      = 7;
    localparam int DIV_LAT = 2;

    logic               clk;
    logic               rst;
    logic               start;
    logic [2:0]         nb;
    logic [NC-1:0][23:0] xSum, ySum, mass;
    logic [NC-1:0][8:0] prevX;
    logic [NC-1:0][7:0] prevY;
    logic [23:0]        divDividend, divDivisor, divQuotient;
    logic               divValidOut, divValidIn;
    logic [NC-1:0][8:0] centX;
    logic [NC-1:0][7:0] centY;
    logic               busy, done, converged, timeoutErr;

    typedef struct {
        logic [23:0] dvd;
        logic [23:0] dvs;
    } launch_t;

    typedef struct {
        int                 testId;
        logic               conv;
        logic               terr;
        logic [NC-1:0][8:0] cx;
        logic [NC-1:0][7:0] cy;
    } doneExp_t;

    launch_t  launchQ[$];
    doneExp_t doneQ[$];

    int checkCount  = 0;
    int errorCount  = 0;
    int launchCount = 0;
    int doneCount   = 0;
    int doneBase    = 0;
    logic divRespond = 1'b1;

    centroid_div_sched #(
        .NUM_CLUSTERS(NC), .X_MAX(319), .Y_MAX(179), .TIMEOUT(64)
    ) dut (
        .clk_in(clk),
        .rst_in(rst),
        .start_in(start),
        .num_balls(nb),
        .x_sum_in(xSum),
        .y_sum_in(ySum),
        .mass_in(mass),
        .centroids_x_in(prevX),
        .centroids_y_in(prevY),
        .div_dividend_out(divDividend),
        .div_divisor_out(divDivisor),
        .div_valid_out(divValidOut),
        .div_quotient_in(divQuotient),
        .div_valid_in(divValidIn),
        .centroids_x_out(centX),
        .centroids_y_out(centY),
        .busy_out(busy),
        .done_out(done),
        .converged_out(converged),
        .timeout_err_out(timeoutErr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clearInputs();
        nb = 3'd0; xSum = '0; ySum = '0; mass = '0; prevX = '0; prevY = '0;
    endtask

    task automatic applyStimulus();
        doneBase = doneCount;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic waitDone(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (doneCount > doneBase) break;
            @(negedge clk); #1;
        end
        checkOutput(name, doneCount - doneBase, 1);
        @(posedge clk); #1;
    endtask

    // Behavioural divider: answers each launch DIV_LAT cycles later unless silenced.
    initial begin
        divValidIn  = 1'b0;
        divQuotient = '0;
        forever begin
            @(negedge clk);
            if (divValidOut) begin
                logic [23:0] q;
                launchCount++;
                q = divDividend / divDivisor;
                if (divRespond) begin
                    repeat (DIV_LAT) @(posedge clk);
                    #1 divValidIn = 1'b1; divQuotient = q;
                    @(posedge clk);
                    #1 divValidIn = 1'b0;
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT launches a division or finishes a pass.
    initial begin
        forever begin
            @(negedge clk);
            if (divValidOut) begin
                if (launchQ.size() == 0) begin
                    checkCount++; errorCount++;
                    $display("[TB] FAIL unexpected launch: got dividend %0d divisor %0d expected none",
                             divDividend, divDivisor);
                end else begin
                    launch_t l;
                    l = launchQ.pop_front();
                    checkOutput("launch dividend", 32'(divDividend), 32'(l.dvd));
                    checkOutput("launch divisor", 32'(divDivisor), 32'(l.dvs));
                end
            end
            if (done) begin
                if (doneQ.size() == 0) begin
                    checkCount++; errorCount++;
                    $display("[TB] FAIL unexpected done: got done_out 1 expected 0");
                end else begin
                    doneExp_t e;
                    e = doneQ.pop_front();
                    checkOutput($sformatf("t%0d converged", e.testId), 32'(converged), 32'(e.conv));
                    checkOutput($sformatf("t%0d timeout_err", e.testId), 32'(timeoutErr), 32'(e.terr));
                    for (int i = 0; i < NC; i++) begin
                        checkOutput($sformatf("t%0d cx[%0d]", e.testId, i), 32'(centX[i]), 32'(e.cx[i]));
                        checkOutput($sformatf("t%0d cy[%0d]", e.testId, i), 32'(centY[i]), 32'(e.cy[i]));
                    end
                end
                doneCount++;
            end
        end
    end

    initial begin
        doneExp_t e;
        int base;

        start = 1'b0; rst = 1'b1;
        clearInputs();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("reset busy", 32'(busy), 0);
        checkOutput("reset done", 32'(done), 0);
        checkOutput("reset div_valid", 32'(divValidOut), 0);
        checkOutput("reset timeout_err", 32'(timeoutErr), 0);
        checkOutput("reset cx[0]", 32'(centX[0]), 0);
        checkOutput("reset dividend", 32'(divDividend), 0);

        // Test 1: single cluster 1600/10, 900/10
        clearInputs();
        nb = 3'd1; xSum[0] = 24'd1600; ySum[0] = 24'd900; mass[0] = 24'd10;
        launchQ.push_back('{24'd1600, 24'd10});
        launchQ.push_back('{24'd900, 24'd10});
        e.testId = 1; e.conv = 1'b0; e.terr = 1'b0; e.cx = '0; e.cy = '0;
        e.cx[0] = 9'd160; e.cy[0] = 8'd90;
        doneQ.push_back(e);
        base = launchCount;
        applyStimulus();
        @(negedge clk);
        checkOutput("t1 busy mid-pass", 32'(busy), 1);
        waitDone("t1 done seen", 300);
        checkOutput("t1 launches", launchCount - base, 2);

        // Test 2: cluster 1 has zero mass and must be skipped
        clearInputs();
        nb = 3'd3;
        mass[0] = 24'd10; xSum[0] = 24'd1000; ySum[0] = 24'd500;
        mass[1] = 24'd0;  xSum[1] = 24'd999;  ySum[1] = 24'd999;
        mass[2] = 24'd20; xSum[2] = 24'd3000; ySum[2] = 24'd1200;
        mass[3] = 24'd5;  xSum[3] = 24'd500;  ySum[3] = 24'd500;
        prevX[0] = 9'd100; prevY[0] = 8'd50;
        prevX[1] = 9'd50;  prevY[1] = 8'd40;
        prevX[2] = 9'd7;   prevY[2] = 8'd9;
        for (int i = 3; i < NC; i++) begin
            prevX[i] = 9'(200 + i);
            prevY[i] = 8'(100 + i);
        end
        launchQ.push_back('{24'd1000, 24'd10});
        launchQ.push_back('{24'd500, 24'd10});
        launchQ.push_back('{24'd3000, 24'd20});
        launchQ.push_back('{24'd1200, 24'd20});
        e.testId = 2; e.conv = 1'b0; e.terr = 1'b0; e.cx = prevX; e.cy = prevY;
        e.cx[2] = 9'd150; e.cy[2] = 8'd60;
        doneQ.push_back(e);
        base = launchCount;
        applyStimulus();
        waitDone("t2 done seen", 400);
        checkOutput("t2 launches", launchCount - base, 4);

        // Test 3: quotients 400 and 200 clamp to the frame limits
        clearInputs();
        nb = 3'd1; xSum[0] = 24'd4000; ySum[0] = 24'd2000; mass[0] = 24'd10;
        mass[1] = 24'd5; xSum[1] = 24'd50; ySum[1] = 24'd50;
        prevX[1] = 9'd33; prevY[1] = 8'd44;
        launchQ.push_back('{24'd4000, 24'd10});
        launchQ.push_back('{24'd2000, 24'd10});
        e.testId = 3; e.conv = 1'b0; e.terr = 1'b0; e.cx = prevX; e.cy = prevY;
        e.cx[0] = 9'd319; e.cy[0] = 8'd179;
        doneQ.push_back(e);
        base = launchCount;
        applyStimulus();
        waitDone("t3 done seen", 300);
        checkOutput("t3 launches", launchCount - base, 2);

        // Test 4: nothing moves, plus an ignored start pulse mid-pass
        clearInputs();
        nb = 3'd2;
        mass[0] = 24'd10; xSum[0] = 24'd1600; ySum[0] = 24'd900;
        mass[1] = 24'd3;  xSum[1] = 24'd90;   ySum[1] = 24'd60;
        prevX[0] = 9'd160; prevY[0] = 8'd90;
        prevX[1] = 9'd30;  prevY[1] = 8'd20;
        launchQ.push_back('{24'd1600, 24'd10});
        launchQ.push_back('{24'd900, 24'd10});
        launchQ.push_back('{24'd90, 24'd3});
        launchQ.push_back('{24'd60, 24'd3});
        e.testId = 4; e.conv = 1'b1; e.terr = 1'b0; e.cx = prevX; e.cy = prevY;
        doneQ.push_back(e);
        base = launchCount;
        applyStimulus();
        repeat (4) @(posedge clk);
        #1 start = 1'b1; nb = 3'd7;
        for (int i = 0; i < NC; i++) mass[i] = 24'd5;
        @(posedge clk); #1 start = 1'b0;
        waitDone("t4 done seen", 400);
        checkOutput("t4 launches", launchCount - base, 4);

        // Test 5: silent divider, both divisions time out
        clearInputs();
        divRespond = 1'b0;
        nb = 3'd1; xSum[0] = 24'd1600; ySum[0] = 24'd900; mass[0] = 24'd10;
        prevX[0] = 9'd5; prevY[0] = 8'd6;
        launchQ.push_back('{24'd1600, 24'd10});
        launchQ.push_back('{24'd900, 24'd10});
        e.testId = 5; e.conv = 1'b1; e.terr = 1'b1; e.cx = prevX; e.cy = prevY;
        doneQ.push_back(e);
        base = launchCount;
        applyStimulus();
        waitDone("t5 done seen", 600);
        checkOutput("t5 launches", launchCount - base, 2);
        checkOutput("t5 timeout sticky", 32'(timeoutErr), 1);
        divRespond = 1'b1;

        // Test 6: no active clusters, done exactly two cycles after start
        clearInputs();
        prevX[0] = 9'd77; prevY[0] = 8'd66;
        e.testId = 6; e.conv = 1'b1; e.terr = 1'b1; e.cx = prevX; e.cy = prevY;
        doneQ.push_back(e);
        base = launchCount;
        applyStimulus();
        @(negedge clk);
        checkOutput("t6 done one cycle after start", 32'(done), 0);
        @(negedge clk);
        checkOutput("t6 done two cycles after start", 32'(done), 1);
        checkOutput("t6 converged", 32'(converged), 1);
        waitDone("t6 done seen", 20);
        checkOutput("t6 launches", launchCount - base, 0);

        // Test 7: reset while waiting on the divider
        clearInputs();
        nb = 3'd1; xSum[0] = 24'd1600; ySum[0] = 24'd900; mass[0] = 24'd10;
        prevX[0] = 9'd12; prevY[0] = 8'd13;
        launchQ.push_back('{24'd1600, 24'd10});
        base = launchCount;
        applyStimulus();
        for (int i = 0; i < 50; i++) begin
            if (launchCount > base) break;
            @(negedge clk); #1;
        end
        checkOutput("t7 launch seen", launchCount - base, 1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("t7 reset busy", 32'(busy), 0);
        checkOutput("t7 reset cx[0]", 32'(centX[0]), 0);
        checkOutput("t7 reset cy[0]", 32'(centY[0]), 0);
        checkOutput("t7 reset timeout_err", 32'(timeoutErr), 0);
        checkOutput("t7 reset dividend", 32'(divDividend), 0);
        checkOutput("t7 reset divisor", 32'(divDivisor), 0);
        #1 rst = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("t7 stray strobe ignored", 32'(busy), 0);
        checkOutput("t7 cx[0] after strobe", 32'(centX[0]), 0);

        checkOutput("launch queue drained", launchQ.size(), 0);
        checkOutput("done queue drained", doneQ.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
